// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store front-end (package lsu_pkg).
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_t;

  // The raw encoding 2'b11 behaves as a full word.
  function automatic size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lo);
    case (size)
      HALF:    return addr_lo[0];
      WORD:    return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Drop the low address bits that a half or word access cannot use.
  function automatic logic [1:0] align_offset(input size_t size, input logic [1:0] addr_lo);
    case (size)
      HALF:    return {addr_lo[1], 1'b0};
      WORD:    return 2'b00;
      default: return addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus the word-addressed data memory port.
// master: execute stage and memory side; slave: the load/store unit.
interface mem_access_unit_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [AW-3:0] dm_addr;
  logic          dm_rd;
  logic          dm_wr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, dm_addr, dm_rd, dm_wr, dm_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, dm_addr, dm_rd, dm_wr, dm_wdata
  );
endinterface

// File: rtl/mem_access_unit_lane_merge.sv
// Byte-lane logic: merges store data into a word and extracts/extends loads.
// Little-endian: byte k lives in [8k+7:8k].
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  input  size_t       size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  output logic [31:0] merged,
  output logic [31:0] load_val
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Replace only the addressed lane(s) of the old word.
  always_comb begin
    merged = old_word;
    case (size)
      BYTE:    merged[{offset, 3'b000} +: 8] = store_data[7:0];
      HALF:    merged[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      default: merged = store_data;
    endcase
  end

  // Pick the addressed lane and widen it to 32 bits.
  always_comb begin
    sel_byte = old_word[{offset, 3'b000} +: 8];
    sel_half = old_word[{offset[1], 4'b0000} +: 16];
    case (size)
      BYTE:    load_val = {{24{sign_ext & sel_byte[7]}}, sel_byte};
      HALF:    load_val = {{16{sign_ext & sel_half[15]}}, sel_half};
      default: load_val = old_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end for the 128-word data memory.
// Optional build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned
// requests skip memory and complete with resp_err; otherwise the address is
// forced to alignment and resp_err stays 0.
//
// state | meaning
// IDLE  | ready for a request
// RD    | reading the addressed word (loads and sub-word stores)
// WR    | writing the word (word stores, merged sub-word stores)
// RESP  | one-cycle completion pulse
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);

  state_t        state, state_nxt;
  size_t         in_size;
  logic          accept;
  logic          trap_now;
  logic [1:0]    in_offset;

  logic          r_we;
  size_t         r_size;
  logic          r_signed;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_err;
  logic [DW-1:0] word_q;

  logic [31:0]   merged;
  logic [31:0]   load_val;

  assign in_size = decode_size(bus.req_size);
  assign accept  = (state == IDLE) && bus.req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_now  = is_misaligned(in_size, bus.req_addr[1:0]);
  assign in_offset = bus.req_addr[1:0];
`else
  assign trap_now  = 1'b0;
  assign in_offset = align_offset(in_size, bus.req_addr[1:0]);
`endif

  // Latch the accepted request and capture the read word in RD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_size   <= BYTE;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      word_q   <= '0;
    end else begin
      if (accept) begin
        r_we     <= bus.req_we;
        r_size   <= in_size;
        r_signed <= bus.req_signed;
        r_addr   <= {bus.req_addr[AW-1:2], in_offset};
        r_wdata  <= bus.req_wdata;
        r_err    <= trap_now;
      end
      if (state == RD) begin
        word_q <= bus.dm_rdata;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; only word stores skip the read.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (trap_now)                          state_nxt = RESP;
          else if (bus.req_we && in_size == WORD) state_nxt = WR;
          else                                    state_nxt = RD;
        end
      end
      RD:      state_nxt = r_we ? WR : RESP;
      WR:      state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  lsu_lane_merge u_lane_merge (
    .old_word   (word_q),
    .store_data (r_wdata),
    .size       (r_size),
    .offset     (r_addr[1:0]),
    .sign_ext   (r_signed),
    .merged     (merged),
    .load_val   (load_val)
  );

  // Outputs decoded from state and the latched request.
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.dm_rd      = (state == RD);
    bus.dm_wr      = (state == WR);
    bus.dm_addr    = r_addr[AW-1:2];
    bus.dm_wdata   = (state == WR) ? merged : '0;
    bus.resp_valid = (state == RESP);
    bus.resp_err   = (state == RESP) && r_err;
    bus.resp_rdata = ((state == RESP) && !r_we && !r_err) ? load_val : '0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural data memory and a
// queue of expected responses.
module tb_mem_access_unit;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mem_access_unit_if #(.AW(9), .DW(32)) bus ();

  mem_access_unit #(.AW(9), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:127];
  assign bus.dm_rdata = mem[bus.dm_addr];
  always @(posedge clk) if (bus.dm_wr) mem[bus.dm_addr] <= bus.dm_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          lat;
    int          rd_cyc;
    int          wr_cyc;
    int          rd_n;
    int          wr_n;
    logic [6:0]  rd_a;
    logic [6:0]  wr_a;
    logic [31:0] wr_d;
  } obs_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, " rdata"}, bus.resp_rdata, e.rdata);
      chk({tag, " err"}, {31'b0, bus.resp_err}, {31'b0, e.err});
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic s, input logic [1:0] off);
    logic [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = w >> (8 * int'(off));
    b  = sh[7:0];
    h  = sh[15:0];
    if (sz == 2'd0) return s ? 32'(b) : 32'(sh[7:0]);
    if (sz == 2'd1) return s ? 32'(h) : 32'(sh[15:0]);
    return w;
  endfunction

  // One request from IDLE to its response; fields of the trip are returned in o.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [8:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, output obs_t o);
    exp_t e;
    o = '{lat: -1, rd_cyc: -1, wr_cyc: -1, rd_n: 0, wr_n: 0, rd_a: '0, wr_a: '0, wr_d: '0};
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    chk({tag, " ready"}, {31'b0, bus.req_ready}, 32'd1);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.dm_rd) begin o.rd_n++; o.rd_cyc = c; o.rd_a = bus.dm_addr; end
      if (bus.dm_wr) begin o.wr_n++; o.wr_cyc = c; o.wr_a = bus.dm_addr; o.wr_d = bus.dm_wdata; end
      if (bus.resp_valid) begin
        o.lat = c;
        pop_cmp(tag);
        break;
      end
    end
    if (o.lat < 0) begin
      chk({tag, " timeout"}, 32'd1, 32'd0);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    obs_t        o;
    logic [31:0] w4, w5, w, exp;
    logic [1:0]  sz, off;
    logic        sg;
    int          accepts, resps, cyc;
    exp_t        e;

    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (3) @(negedge clk);

    chk("rst ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst resp_err", {31'b0, bus.resp_err}, 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst dm_rd", {31'b0, bus.dm_rd}, 32'd0);
    chk("rst dm_wr", {31'b0, bus.dm_wr}, 32'd0);
    chk("rst dm_addr", {25'b0, bus.dm_addr}, 32'd0);
    chk("rst dm_wdata", bus.dm_wdata, 32'd0);
    rst_n = 1'b1;

    do_req("st_w", 1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0, o);
    chk("st_w lat", o.lat, 2);
    chk("st_w rd_n", o.rd_n, 0);
    chk("st_w wr_n", o.wr_n, 1);
    chk("st_w dm_addr", {25'b0, o.wr_a}, 32'd4);
    chk("st_w wdata", o.wr_d, 32'hDEADBEEF);

    do_req("ld_w", 1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, o);
    chk("ld_w lat", o.lat, 2);
    chk("ld_w dm_addr", {25'b0, o.rd_a}, 32'd4);
    chk("ld_w wr_n", o.wr_n, 0);

    do_req("st_w2", 1'b1, 2'b10, 1'b0, 9'h010, 32'h11223344, 32'h0, 1'b0, o);
    do_req("st_b", 1'b1, 2'b00, 1'b0, 9'h012, 32'h000000AA, 32'h0, 1'b0, o);
    chk("st_b lat", o.lat, 3);
    chk("st_b wdata", o.wr_d, 32'h11AA3344);
    chk("st_b rd_n", o.rd_n, 1);
    chk("st_b rd before wr", o.wr_cyc - o.rd_cyc, 1);
    chk("st_b mem", mem[4], 32'h11AA3344);

    w4 = 32'h8000F0FF;
    do_req("st_w3", 1'b1, 2'b10, 1'b0, 9'h010, w4, 32'h0, 1'b0, o);
    do_req("ld_bs", 1'b0, 2'b00, 1'b1, 9'h010, 32'h0, 32'hFFFFFFFF, 1'b0, o);
    chk("ld_bs lat", o.lat, 2);
    do_req("ld_hu", 1'b0, 2'b01, 1'b0, 9'h012, 32'h0, 32'h00008000, 1'b0, o);
    do_req("ld_hs", 1'b0, 2'b01, 1'b1, 9'h012, 32'h0, 32'hFFFF8000, 1'b0, o);
    do_req("ld_bu3", 1'b0, 2'b00, 1'b0, 9'h013, 32'h0, 32'h00000080, 1'b0, o);

`ifdef LSU_MISALIGN_TRAP_EN
    do_req("mis_h", 1'b0, 2'b01, 1'b0, 9'h011, 32'h0, 32'h0, 1'b1, o);
    chk("mis_h lat", o.lat, 1);
    chk("mis_h rd_n", o.rd_n, 0);
    chk("mis_h wr_n", o.wr_n, 0);
    do_req("mis_sw", 1'b1, 2'b10, 1'b0, 9'h012, 32'h12345678, 32'h0, 1'b1, o);
    chk("mis_sw wr_n", o.wr_n, 0);
    chk("mis_sw mem", mem[4], w4);
`else
    do_req("mis_h", 1'b0, 2'b01, 1'b0, 9'h011, 32'h0, 32'h0000F0FF, 1'b0, o);
    chk("mis_h lat", o.lat, 2);
    chk("mis_h rd_n", o.rd_n, 1);
    do_req("mis_lw", 1'b0, 2'b10, 1'b0, 9'h013, 32'h0, w4, 1'b0, o);
    chk("mis_lw dm_addr", {25'b0, o.rd_a}, 32'd4);
`endif

    do_req("st_w5", 1'b1, 2'b10, 1'b0, 9'h014, 32'h0, 32'h0, 1'b0, o);
    do_req("st_h", 1'b1, 2'b01, 1'b0, 9'h016, 32'h1234BEEF, 32'h0, 1'b0, o);
    chk("st_h lat", o.lat, 3);
    chk("st_h wdata", o.wr_d, 32'hBEEF0000);
    w5 = 32'hBEEF0000;
    do_req("ld_sz3", 1'b0, 2'b11, 1'b0, 9'h014, 32'h0, w5, 1'b0, o);
    chk("ld_sz3 lat", o.lat, 2);

    for (int i = 0; i < 6; i++) begin
      w   = $urandom;
      sz  = 2'($urandom_range(0, 2));
      sg  = 1'($urandom_range(0, 1));
      off = 2'($urandom_range(0, 3));
      if (sz == 2'd1) off[0] = 1'b0;
      if (sz == 2'd2) off = 2'b00;
      exp = ref_load(w, sz, sg, off);
      do_req("rnd_st", 1'b1, 2'b10, 1'b0, 9'(9'h040 + 4 * i), w, 32'h0, 1'b0, o);
      do_req("rnd_ld", 1'b0, sz, sg, 9'(9'h040 + 4 * i) | {7'b0, off}, 32'h0, exp, 1'b0, o);
    end

    // Back-to-back with req_valid held high, alternating words 4 and 5.
    accepts = 0;
    resps   = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 9'h010;
    for (int c = 0; c < 20; c++) begin
      if (bus.resp_valid) begin
        resps++;
        pop_cmp("b2b");
      end
      if (accepts == 3) bus.req_valid = 1'b0;
      bus.req_addr = (accepts % 2 == 1) ? 9'h014 : 9'h010;
      if (bus.req_valid && bus.req_ready) begin
        accepts++;
        e.rdata = (bus.req_addr == 9'h010) ? w4 : w5;
        e.err   = 1'b0;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    chk("b2b accepts", accepts, 3);
    chk("b2b resps", resps, 3);

    // Reset during the WR cycle of a byte store.
    do_req("st_w6", 1'b1, 2'b10, 1'b0, 9'h014, 32'h11223344, 32'h0, 1'b0, o);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_addr   = 9'h015;
    bus.req_wdata  = 32'h00000055;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    cyc = 0;
    while (!bus.dm_wr && cyc < 6) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_wr reached", {31'b0, bus.dm_wr}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_wr mem", mem[5], 32'h11225544);
    chk("rst_wr resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_wr ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_wr dm_wr", {31'b0, bus.dm_wr}, 32'd0);
    chk("rst_wr dm_rd", {31'b0, bus.dm_rd}, 32'd0);
    chk("rst_wr dm_addr", {25'b0, bus.dm_addr}, 32'd0);
    chk("rst_wr dm_wdata", bus.dm_wdata, 32'd0);
    chk("rst_wr resp_rdata", bus.resp_rdata, 32'd0);
    rst_n = 1'b1;
    resps = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid) resps++;
    end
    chk("rst_wr no resp", resps, 0);
    do_req("ld_after_rst", 1'b0, 2'b10, 1'b0, 9'h014, 32'h0, 32'h11225544, 1'b0, o);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
